program_memory_loader_ctrl: RTL and testbench

Sequencer for the writable program memory: at boot it owns the memory and writes a program word stream from a loader source (UART/debug bridge). After the last word it hands the memory to the CPU fetch port. It stalls the CPU until the load completes and reports load errors. It sits between the single-port program RAM, the loader and the instruction-fetch stage.

---
 rtl/program_memory_pkg.sv | 16 +
 rtl/load_checksum_acc.sv | 30 +++
 rtl/program_memory_loader_ctrl.sv | 135 +++++++++++++
 tb/tb_program_memory_loader_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/program_memory_pkg.sv
// Shared definitions for the program memory loader: controller states,
// the NOP instruction word and default geometry.
package program_memory_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int unsigned DEFAULT_MEMORY_DEPTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH   = 32;

endpackage

// File: rtl/load_checksum_acc.sv
// Running mod-2^DATA_WIDTH sum of the words written during a load, compared
// against the checksum word that terminates the stream.
// Used only when PROGMEM_CHECKSUM_EN is defined.
module load_checksum_acc
  import program_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  match
);

  logic [DATA_WIDTH-1:0] sum;

  // Accumulate every written word; restart whenever a new load begins.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  assign match = (sum == data);

endmodule

// File: rtl/program_memory_loader_ctrl.sv
// Program memory sequencer: owns the RAM during boot load, then hands it to
// the instruction-fetch port. Stalls the CPU until the load completes.
// Optional feature macro: PROGMEM_CHECKSUM_EN (last loader word is a
// checksum over the written words instead of a data word).
module program_memory_loader_ctrl
  import program_memory_pkg::*;
#(
  parameter  int unsigned MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
  parameter  int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  localparam int unsigned ADDR_WIDTH   = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  LoadValid,
  input  logic [DATA_WIDTH-1:0] LoadData,
  input  logic                  LoadLast,
  output logic                  LoadReady,
  input  logic                  ReloadReq,
  input  logic                  FetchValid,
  input  logic [DATA_WIDTH-1:0] FetchAddress,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstructionValid,
  output logic                  CpuStall,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemReadData,
  output logic [ADDR_WIDTH:0]   LoadCount,
  output logic                  LoadError,
  output logic                  AddressError
);

  state_t                state, next;
  logic [ADDR_WIDTH:0]   count;
  logic                  ivalid_q, ierr_q, lerr_q;
  logic                  full, wr, set_err, enter_load, fetch_bad;
  logic                  chk_last, chk_ok;
  logic [DATA_WIDTH-3:0] word_idx;

  assign full      = (count == (ADDR_WIDTH+1)'(MEMORY_DEPTH));
  assign word_idx  = FetchAddress[DATA_WIDTH-1:2];
  assign fetch_bad = (FetchAddress[1:0] != 2'b00) ||
                     (word_idx >= (DATA_WIDTH-2)'(MEMORY_DEPTH));

`ifdef PROGMEM_CHECKSUM_EN
  assign chk_last = LoadLast;
  load_checksum_acc #(.DATA_WIDTH(DATA_WIDTH)) u_checksum (
    .clk   (clk),
    .reset (reset),
    .clear (enter_load),
    .add   (wr),
    .data  (LoadData),
    .match (chk_ok)
  );
`else
  assign chk_last = 1'b0;
  assign chk_ok   = 1'b1;
`endif

  // Next-state and state-derived strobes; overflow outranks LoadLast.
  always_comb begin
    next         = state;
    LoadReady    = 1'b0;
    CpuStall     = 1'b1;
    MemRead      = 1'b0;
    MemAddress   = count[ADDR_WIDTH-1:0];
    AddressError = 1'b0;
    wr           = 1'b0;
    set_err      = 1'b0;
    case (state)
      LOAD: begin
        LoadReady = 1'b1;
        if (LoadValid && !reset) begin
          if (full) begin
            set_err = 1'b1;
            next    = ERROR;
          end else if (chk_last) begin
            if (chk_ok) begin
              next = RUN;
            end else begin
              set_err = 1'b1;
              next    = ERROR;
            end
          end else begin
            wr = 1'b1;
            if (LoadLast) next = RUN;
          end
        end
      end
      RUN: begin
        CpuStall   = 1'b0;
        MemAddress = FetchAddress[ADDR_WIDTH+1:2];
        if (FetchValid) begin
          if (fetch_bad) AddressError = 1'b1;
          else           MemRead      = 1'b1;
        end
        if (ReloadReq) next = LOAD;
      end
      ERROR: begin
        if (ReloadReq) next = LOAD;
      end
      default: next = LOAD;
    endcase
  end

  assign enter_load = (state != LOAD) && (next == LOAD);

  // State, load counter, fetch response pipeline and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      count    <= '0;
      ivalid_q <= 1'b0;
      ierr_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      state    <= next;
      ivalid_q <= (state == RUN) && FetchValid;
      ierr_q   <= (state == RUN) && FetchValid && fetch_bad;
      if (enter_load)       count <= '0;
      else if (wr && !full) count <= count + 1'b1;
      if (set_err)                           lerr_q <= 1'b1;
      else if (state == ERROR && ReloadReq)  lerr_q <= 1'b0;
    end
  end

  assign MemWrite         = wr;
  assign MemWriteData     = LoadData;
  assign InstructionValid = ivalid_q;
  assign Instruction      = (ivalid_q && !ierr_q) ? MemReadData : DATA_WIDTH'(NOP);
  assign LoadCount        = count;
  assign LoadError        = lerr_q;

endmodule

// File: tb/tb_program_memory_loader_ctrl.sv
// Table-driven bench for program_memory_loader_ctrl at default geometry
// (depth 32, 32-bit words). Optional feature macro: PROGMEM_CHECKSUM_EN.
module tb_program_memory_loader_ctrl;

  typedef struct packed {
    logic        rdy;
    logic        stall;
    logic        mw;
    logic        mr;
    logic [4:0]  maddr;
    logic [31:0] mwd;
    logic        aerr;
    logic        ivld;
    logic [31:0] instr;
    logic [5:0]  lcnt;
    logic        lerr;
  } outs_t;

  typedef struct {
    logic [63:0] name;
    logic        rst, lv, ll, rr, fv;
    logic [31:0] ld, fa, mrd;
    outs_t       want;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        LoadValid = 1'b0, LoadLast = 1'b0, ReloadReq = 1'b0, FetchValid = 1'b0;
  logic [31:0] LoadData = '0, FetchAddress = '0, MemReadData = '0;
  logic        LoadReady, InstructionValid, CpuStall, MemWrite, MemRead, LoadError, AddressError;
  logic [31:0] Instruction, MemWriteData;
  logic [4:0]  MemAddress;
  logic [5:0]  LoadCount;

  int checks = 0;
  int passed = 0;
  vec_t tbl[$];

  program_memory_loader_ctrl #(.MEMORY_DEPTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .LoadValid(LoadValid), .LoadData(LoadData),
    .LoadLast(LoadLast), .LoadReady(LoadReady), .ReloadReq(ReloadReq),
    .FetchValid(FetchValid), .FetchAddress(FetchAddress), .Instruction(Instruction),
    .InstructionValid(InstructionValid), .CpuStall(CpuStall), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemReadData(MemReadData), .LoadCount(LoadCount), .LoadError(LoadError),
    .AddressError(AddressError)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [63:0] name,
    input logic rst, input logic lv, input logic [31:0] ld, input logic ll,
    input logic rr, input logic fv, input logic [31:0] fa, input logic [31:0] mrd,
    input logic rdy, input logic stall, input logic mw, input logic mr,
    input logic [4:0] maddr, input logic aerr, input logic ivld,
    input logic [31:0] instr, input logic [5:0] lcnt, input logic lerr);
    vec_t v;
    v.name = name; v.rst = rst; v.lv = lv; v.ld = ld; v.ll = ll;
    v.rr = rr; v.fv = fv; v.fa = fa; v.mrd = mrd;
    v.want = '{rdy: rdy, stall: stall, mw: mw, mr: mr, maddr: maddr, mwd: ld,
               aerr: aerr, ivld: ivld, instr: instr, lcnt: lcnt, lerr: lerr};
    return v;
  endfunction

  // Drive one cycle of inputs after the edge, compare mid-cycle.
  task automatic apply(input vec_t v);
    outs_t act, want;
    @(posedge clk); #1;
    reset = v.rst; LoadValid = v.lv; LoadData = v.ld; LoadLast = v.ll;
    ReloadReq = v.rr; FetchValid = v.fv; FetchAddress = v.fa; MemReadData = v.mrd;
    @(negedge clk);
    act = '{rdy: LoadReady, stall: CpuStall, mw: MemWrite, mr: MemRead,
            maddr: MemAddress, mwd: MemWriteData, aerr: AddressError,
            ivld: InstructionValid, instr: Instruction, lcnt: LoadCount, lerr: LoadError};
    want = v.want;
    if (!want.mw) begin act.mwd = '0; want.mwd = '0; end
    if (!(want.mw || want.mr)) begin act.maddr = '0; want.maddr = '0; end
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h required %h", v.name, act, want);
  endtask

  initial begin
    //                name      rst lv ld            ll rr fv fa          mrd            rdy st mw mr ma    ae iv instr         cnt lerr
`ifdef PROGMEM_CHECKSUM_EN
    tbl.push_back(mk("ck_w1",   0, 1, 32'd1,        0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("ck_w2",   0, 1, 32'd2,        0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("ck_sum3", 0, 1, 32'd3,        1, 0, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        2, 0));
    tbl.push_back(mk("ck_run",  0, 0, 32'd0,        0, 1, 0, 32'h0,     32'h0,         0, 0, 0, 0, 5'd0, 0, 0, 32'h0,        2, 0));
    tbl.push_back(mk("ck_rld",  0, 0, 32'd0,        0, 0, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("ck_w1b",  0, 1, 32'd1,        0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("ck_w2b",  0, 1, 32'd2,        0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("ck_bad4", 0, 1, 32'd4,        1, 0, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        2, 0));
    tbl.push_back(mk("ck_err",  0, 0, 32'd0,        0, 1, 0, 32'h0,     32'h0,         0, 1, 0, 0, 5'd0, 0, 0, 32'h0,        2, 1));
    tbl.push_back(mk("ck_back", 0, 0, 32'd0,        0, 0, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        0, 0));
`else
    tbl.push_back(mk("rst",     0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("ld0",     0, 1, 32'h20080005, 0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("ld1",     0, 1, 32'h20090003, 0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("ld2last", 0, 1, 32'h01095020, 1, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd2, 0, 0, 32'h0,        2, 0));
    tbl.push_back(mk("run",     0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,         0, 0, 0, 0, 5'd0, 0, 0, 32'h0,        3, 0));
    tbl.push_back(mk("f0",      0, 0, 32'h0,        0, 0, 1, 32'h0,     32'h0,         0, 0, 0, 1, 5'd0, 0, 0, 32'h0,        3, 0));
    tbl.push_back(mk("f4",      0, 0, 32'h0,        0, 0, 1, 32'h4,     32'h20080005,  0, 0, 0, 1, 5'd1, 0, 1, 32'h20080005, 3, 0));
    tbl.push_back(mk("f8",      0, 0, 32'h0,        0, 0, 1, 32'h8,     32'h20090003,  0, 0, 0, 1, 5'd2, 0, 1, 32'h20090003, 3, 0));
    tbl.push_back(mk("fdone",   0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h01095020,  0, 0, 0, 0, 5'd0, 0, 1, 32'h01095020, 3, 0));
    tbl.push_back(mk("mis6",    0, 0, 32'h0,        0, 0, 1, 32'h6,     32'hdead0000,  0, 0, 0, 0, 5'd0, 1, 0, 32'h0,        3, 0));
    tbl.push_back(mk("oor80",   0, 0, 32'h0,        0, 0, 1, 32'h80,    32'hbeef0000,  0, 0, 0, 0, 5'd0, 1, 1, 32'h0,        3, 0));
    tbl.push_back(mk("oornop",  0, 0, 32'h0,        0, 0, 0, 32'h0,     32'hcafe0000,  0, 0, 0, 0, 5'd0, 0, 1, 32'h0,        3, 0));
    tbl.push_back(mk("f7c",     0, 0, 32'h0,        0, 0, 1, 32'h7c,    32'h0,         0, 0, 0, 1, 5'd31,0, 0, 32'h0,        3, 0));
    tbl.push_back(mk("rldfet",  0, 0, 32'h0,        0, 1, 1, 32'h4,     32'h00001234,  0, 0, 0, 1, 5'd1, 0, 1, 32'h00001234, 3, 0));
    tbl.push_back(mk("rldlast", 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h20090003,  1, 1, 0, 0, 5'd0, 0, 1, 32'h20090003, 0, 0));
    tbl.push_back(mk("ldignr",  0, 0, 32'h0,        0, 1, 1, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("rw0",     0, 1, 32'haaaa0001, 0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd0, 0, 0, 32'h0,        0, 0));
    tbl.push_back(mk("rw1",     0, 1, 32'haaaa0002, 0, 0, 0, 32'h0,     32'h0,         1, 1, 1, 0, 5'd1, 0, 0, 32'h0,        1, 0));
    tbl.push_back(mk("midrst",  1, 0, 32'h0,        0, 1, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        2, 0));
    tbl.push_back(mk("postrst", 0, 0, 32'h0,        0, 0, 0, 32'h0,     32'h0,         1, 1, 0, 0, 5'd0, 0, 0, 32'h0,        0, 0));
`endif

    foreach (tbl[i]) apply(tbl[i]);

    // Overflow: 32 accepted writes, the 33rd is refused and errors out.
    for (int unsigned i = 0; i < 32; i++)
      apply(mk("ovf_wr", 0, 1, 32'h100 + i, 0, 0, 0, 32'h0, 32'h0,
               1, 1, 1, 0, 5'(i), 0, 0, 32'h0, 6'(i), 0));
    apply(mk("ovf33",   0, 1, 32'h999, 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 5'd0, 0, 0, 32'h0, 32, 0));
    apply(mk("ovf_err", 0, 1, 32'h777, 0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 5'd0, 0, 0, 32'h0, 32, 1));
    apply(mk("err_rr",  0, 0, 32'h0,   0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 0, 5'd0, 0, 0, 32'h0, 32, 1));
    apply(mk("err_ld",  0, 0, 32'h0,   0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 0, 5'd0, 0, 0, 32'h0, 0,  0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
